// File: rtl/hdio_pkg.sv
// Shared types and frame constants for the half-duplex pad controller.
// Build option: HDIO_PARITY_EN adds an even-parity bit to both directions.
package hdio_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TX_START,
        S_TX_DATA,
        S_TX_PAR,
        S_TX_STOP,
        S_TURN,
        S_RX_WAIT,
        S_RX_START,
        S_RX_DATA,
        S_RX_PAR,
        S_RX_STOP
    } hdio_state_e;

    localparam int DATA_BITS = 8;

`ifdef HDIO_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // start + data + optional parity + stop
    localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + 1;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/hdio_bit_timer.sv
// Loadable down-counter: done when it reaches zero, half when it passes HALF_AT.
// Used for bit periods, line turnaround and the response timeout.
module hdio_bit_timer
    import hdio_pkg::*;
#(
    parameter int W       = 4,
    parameter int HALF_AT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done,
    output logic         half
);

    logic [W-1:0] count;

    // Holds at zero once expired so a pending expiry is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);
    assign half = (count == W'(HALF_AT));

endmodule

// File: rtl/half_duplex_io_ctrl.sv
// Single-pad half-duplex controller: sends a command byte, turns the line
// around and captures the response byte. Build option: HDIO_PARITY_EN.
module half_duplex_io_ctrl
    import hdio_pkg::*;
#(
    parameter int BIT_CYCLES   = 16,
    parameter int TURN_CYCLES  = 4,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       TX_VALID,
    output logic       TX_READY,
    input  logic [7:0] TX_DATA,
    output logic       RX_VALID,
    output logic [7:0] RX_DATA,
    output logic       RX_ERR,
    output logic       RX_TIMEOUT,
    output logic       PAD_T,
    output logic       PAD_I,
    input  logic       PAD_O
);

    localparam int BT_MAX = (BIT_CYCLES > TURN_CYCLES) ? BIT_CYCLES : TURN_CYCLES;
    localparam int BT_W   = $clog2(BT_MAX);
    localparam int TO_W   = $clog2(TIMEOUT_BITS * BIT_CYCLES);
    localparam int BC_W   = $clog2(DATA_BITS);

    localparam logic [BT_W-1:0] BIT_LOAD  = BT_W'(BIT_CYCLES - 1);
    localparam logic [BT_W-1:0] TURN_LOAD = BT_W'(TURN_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LOAD   = TO_W'(TIMEOUT_BITS * BIT_CYCLES - 1);
    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(DATA_BITS - 1);

    hdio_state_e           state;
    logic                  pad_s1;
    logic                  pad_s2;
    logic                  rx_line;
    logic                  bt_load;
    logic [BT_W-1:0]       bt_val;
    logic                  bt_done;
    logic                  bt_half;
    logic                  to_load;
    logic                  to_done;
    logic                  to_half_unused;
    logic [BC_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]  tx_shift;
    logic [DATA_BITS-1:0]  rx_shift;
`ifdef HDIO_PARITY_EN
    logic                  tx_par;
    logic                  rx_par;
`endif

    // Pad input is asynchronous; idle-high so the synchroniser resets high.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pad_s1 <= 1'b1;
            pad_s2 <= 1'b1;
        end else begin
            pad_s1 <= PAD_O;
            pad_s2 <= pad_s1;
        end
    end

    assign rx_line = pad_s2;

    hdio_bit_timer #(
        .W       (BT_W),
        .HALF_AT (BIT_CYCLES / 2)
    ) u_bit_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (bt_load),
        .load_val (bt_val),
        .done     (bt_done),
        .half     (bt_half)
    );

    // Second instance keeps the timeout running across a rejected start bit.
    hdio_bit_timer #(
        .W       (TO_W),
        .HALF_AT (0)
    ) u_timeout_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (to_load),
        .load_val (TO_LOAD),
        .done     (to_done),
        .half     (to_half_unused)
    );

    always_comb begin
        bt_load = 1'b0;
        bt_val  = BIT_LOAD;
        to_load = 1'b0;
        case (state)
            S_IDLE:                          bt_load = TX_VALID && TX_READY;
            S_TX_START, S_TX_DATA, S_TX_PAR: bt_load = bt_done;
            S_TX_STOP: begin
                bt_load = bt_done;
                bt_val  = TURN_LOAD;
            end
            S_TURN:                          to_load = bt_done;
            S_RX_WAIT:                       bt_load = !to_done && !rx_line;
            S_RX_START:                      bt_load = bt_half && !rx_line;
            S_RX_DATA, S_RX_PAR:             bt_load = bt_done;
            default:                         bt_load = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            TX_READY   <= 1'b1;
            PAD_T      <= 1'b1;
            PAD_I      <= 1'b1;
            RX_VALID   <= 1'b0;
            RX_ERR     <= 1'b0;
            RX_TIMEOUT <= 1'b0;
            RX_DATA    <= '0;
            bit_cnt    <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
`ifdef HDIO_PARITY_EN
            tx_par     <= 1'b0;
            rx_par     <= 1'b0;
`endif
        end else begin
            RX_VALID   <= 1'b0;
            RX_ERR     <= 1'b0;
            RX_TIMEOUT <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (TX_VALID && TX_READY) begin
                        state    <= S_TX_START;
                        TX_READY <= 1'b0;
                        PAD_T    <= 1'b0;
                        PAD_I    <= 1'b0;
                        tx_shift <= TX_DATA;
`ifdef HDIO_PARITY_EN
                        tx_par   <= even_parity(TX_DATA);
`endif
                    end
                end
                S_TX_START: begin
                    if (bt_done) begin
                        state    <= S_TX_DATA;
                        bit_cnt  <= '0;
                        PAD_I    <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                end
                S_TX_DATA: begin
                    if (bt_done) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef HDIO_PARITY_EN
                            state <= S_TX_PAR;
                            PAD_I <= tx_par;
`else
                            state <= S_TX_STOP;
                            PAD_I <= 1'b1;
`endif
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            PAD_I    <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end
                end
`ifdef HDIO_PARITY_EN
                S_TX_PAR: begin
                    if (bt_done) begin
                        state <= S_TX_STOP;
                        PAD_I <= 1'b1;
                    end
                end
`endif
                S_TX_STOP: begin
                    if (bt_done) begin
                        state <= S_TURN;
                        PAD_T <= 1'b1;
                        PAD_I <= 1'b1;
                    end
                end
                S_TURN: begin
                    if (bt_done) begin
                        state <= S_RX_WAIT;
                    end
                end
                S_RX_WAIT: begin
                    if (to_done) begin
                        state      <= S_IDLE;
                        TX_READY   <= 1'b1;
                        RX_TIMEOUT <= 1'b1;
                    end else if (!rx_line) begin
                        state <= S_RX_START;
                    end
                end
                S_RX_START: begin
                    // A start bit that is gone by its centre was a glitch.
                    if (bt_half) begin
                        if (!rx_line) begin
                            state   <= S_RX_DATA;
                            bit_cnt <= '0;
                        end else begin
                            state <= S_RX_WAIT;
                        end
                    end
                end
                S_RX_DATA: begin
                    if (bt_done) begin
                        rx_shift <= {rx_line, rx_shift[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
`ifdef HDIO_PARITY_EN
                            state <= S_RX_PAR;
`else
                            state <= S_RX_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef HDIO_PARITY_EN
                S_RX_PAR: begin
                    if (bt_done) begin
                        rx_par <= rx_line;
                        state  <= S_RX_STOP;
                    end
                end
`endif
                S_RX_STOP: begin
                    if (bt_done) begin
                        state    <= S_IDLE;
                        TX_READY <= 1'b1;
                        RX_VALID <= 1'b1;
                        RX_DATA  <= rx_shift;
`ifdef HDIO_PARITY_EN
                        RX_ERR   <= !rx_line || (rx_par != even_parity(rx_shift));
`else
                        RX_ERR   <= !rx_line;
`endif
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    TX_READY <= 1'b1;
                    PAD_T    <= 1'b1;
                    PAD_I    <= 1'b1;
                end
            endcase
        end
    end

endmodule
